// File: rtl/mips_cache_pkg.sv
// Shared types and constants for the cache memory-port arbiter and its helpers.
package mips_cache_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_WRITE = 2'd1,
      ARB_READ  = 2'd2
   } arb_state_t;

   localparam logic [3:0] BE_FULL_WORD = 4'hF;

endpackage

// File: rtl/mips_cache_arb_streak_ctr.sv
// Saturating count of reads granted while a write waits; flags when a write must be forced.
module mips_cache_arb_streak_ctr #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic incr_i,
   input  logic clear_i,
   output logic force_write_o
);

   localparam int W = $clog2(STARVE_LIMIT + 1);
   localparam logic [W-1:0] LIMIT_W = W'(STARVE_LIMIT);

   logic [W-1:0] streak_q, streak_d;

   // Clear wins; counting stops at the limit so the forced write stays pending until served.
   always_comb begin
      streak_d = streak_q;
      if (clear_i) begin
         streak_d = '0;
      end else if (incr_i && (streak_q != LIMIT_W)) begin
         streak_d = streak_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

   assign force_write_o = (streak_q == LIMIT_W);

endmodule

// File: rtl/mips_cache_mem_arbiter.sv
// Owns the cache's Avalon master: read misses first, write-buffer drain with anti-starvation.
// Define MIPS_ARB_STRICT_ORDER_EN to drain all pending writes before any read is granted.
module mips_cache_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_write,
   input  logic [31:0] wb_addr,
   input  logic [31:0] wb_writedata,
   input  logic [3:0]  wb_byteenable,
   output logic        wb_active,
   output logic        wb_waitrequest,
   input  logic        rd_req,
   input  logic [31:0] rd_addr,
   output logic        rd_waitrequest,
   output logic [31:0] rd_readdata,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   output logic [3:0]  avm_byteenable,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata
);

   import mips_cache_pkg::*;

   arb_state_t  state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic        grantWrite;

`ifdef MIPS_ARB_STRICT_ORDER_EN
   assign grantWrite = wb_write;
`else
   logic readDone, writeDone, forceWrite;

   assign readDone  = (state_q == ARB_READ) && !avm_waitrequest;
   assign writeDone = (state_q == ARB_WRITE) && !avm_waitrequest;

   mips_cache_arb_streak_ctr #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_streak (
      .clk           (clk),
      .rst           (rst),
      .incr_i        (readDone && wb_write),
      .clear_i       (writeDone || ((state_q == ARB_IDLE) && !wb_write)),
      .force_write_o (forceWrite)
   );

   assign grantWrite = wb_write && (!rd_req || forceWrite);
`endif

   // Outputs are decoded from the state so requester waitrequests track the bus in the same cycle.
   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      wb_active      = 1'b0;
      wb_waitrequest = 1'b1;
      rd_waitrequest = 1'b1;
      rd_readdata    = '0;
      avm_address    = '0;
      avm_read       = 1'b0;
      avm_write      = 1'b0;
      avm_writedata  = '0;
      avm_byteenable = '0;

      case (state_q)
         ARB_IDLE: begin
            if (grantWrite) begin
               state_d = ARB_WRITE;
            end else if (rd_req) begin
               state_d = ARB_READ;
               addr_d  = rd_addr;
            end
         end
         ARB_READ: begin
            avm_read       = 1'b1;
            avm_address    = addr_q;
            avm_byteenable = BE_FULL_WORD;
            if (!avm_waitrequest) begin
               rd_waitrequest = 1'b0;
               rd_readdata    = avm_readdata;
               state_d        = ARB_IDLE;
            end
         end
         ARB_WRITE: begin
            wb_active      = 1'b1;
            avm_write      = wb_write;
            avm_address    = wb_addr;
            avm_writedata  = wb_writedata;
            avm_byteenable = wb_byteenable;
            wb_waitrequest = avm_waitrequest;
            if (!avm_waitrequest) begin
               state_d = ARB_IDLE;
            end
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_mips_cache_mem_arbiter.sv
// Scoreboard bench for mips_cache_mem_arbiter with modelled write buffer, read requester and memory.
// Honours MIPS_ARB_STRICT_ORDER_EN for the expected grant order.
module tb_mips_cache_mem_arbiter;

   typedef struct {
      logic        isWrite;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      int          cycles;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_write, wb_active, wb_waitrequest;
   logic [31:0] wb_addr, wb_writedata;
   logic [3:0]  wb_byteenable;
   logic        rd_req, rd_waitrequest;
   logic [31:0] rd_addr, rd_readdata;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic        avm_read, avm_write, avm_waitrequest;
   logic [3:0]  avm_byteenable;

   logic [31:0] wbAddrMem [16];
   logic [31:0] wbDataMem [16];
   logic [3:0]  wbBeMem   [16];
   logic [31:0] rdAddrMem [16];
   logic [3:0]  wbHead = '0, wbTail = '0, rdHead = '0, rdTail = '0;

   txn_t scbQ[$];
   int   doneCycles[$];
   int   waitStates = 0;
   int   stallCnt = 0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   mips_cache_mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .wb_write        (wb_write),
      .wb_addr         (wb_addr),
      .wb_writedata    (wb_writedata),
      .wb_byteenable   (wb_byteenable),
      .wb_active       (wb_active),
      .wb_waitrequest  (wb_waitrequest),
      .rd_req          (rd_req),
      .rd_addr         (rd_addr),
      .rd_waitrequest  (rd_waitrequest),
      .rd_readdata     (rd_readdata),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_byteenable  (avm_byteenable),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return (a == 32'h1000_0040) ? 32'hDEAD_BEEF : ~a;
   endfunction

   assign wb_write        = (wbHead != wbTail);
   assign wb_addr         = wbAddrMem[wbHead];
   assign wb_writedata    = wbDataMem[wbHead];
   assign wb_byteenable   = wbBeMem[wbHead];
   assign rd_req          = (rdHead != rdTail);
   assign rd_addr         = rdAddrMem[rdHead];
   assign avm_waitrequest = (stallCnt < waitStates);
   assign avm_readdata    = (avm_read && !avm_waitrequest) ? memData(avm_address) : 32'h0;

   // Requesters retire their head entry on their own handshake; memory counts wait states.
   initial forever begin
      @(posedge clk);
      if (!rst && wb_active && !wb_waitrequest) wbHead <= wbHead + 4'd1;
      if (!rst && !rd_waitrequest) rdHead <= rdHead + 4'd1;
      if ((avm_read || avm_write) && avm_waitrequest) stallCnt <= stallCnt + 1;
      else stallCnt <= 0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic isWrite, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be, input int waits);
      txn_t t;
      t.isWrite = isWrite;
      t.addr    = addr;
      t.be      = isWrite ? be : 4'hF;
      t.data    = isWrite ? data : memData(addr);
      t.cycles  = waits + 1;
      if (isWrite) begin
         wbAddrMem[wbTail] = addr;
         wbDataMem[wbTail] = data;
         wbBeMem[wbTail]   = be;
         wbTail            = wbTail + 4'd1;
      end else begin
         rdAddrMem[rdTail] = addr;
         rdTail            = rdTail + 4'd1;
      end
      scbQ.push_back(t);
   endtask

   task automatic waitDrain(input string tag);
      int n = 0;
      while (!(scbQ.size() == 0 && !wb_write && !rd_req) && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      checkOutput(tag, 32'(scbQ.size() == 0 && !wb_write && !rd_req), 32'd1);
   endtask

   // Monitor: every completed bus transaction is matched against the head of the scoreboard.
   initial begin
      int   strobeLen = 0;
      logic prevDone = 1'b0;
      logic [31:0] firstAddr = '0;
      txn_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            strobeLen = 0;
            prevDone  = 1'b0;
         end else begin
            checkOutput("one_strobe", 32'(avm_read && avm_write), 32'd0);
            if (prevDone) begin
               checkOutput("turnaround_idle", 32'({avm_read, avm_write, wb_active}), 32'd0);
               prevDone = 1'b0;
            end else if (avm_read || avm_write) begin
               strobeLen++;
               if (strobeLen == 1) firstAddr = avm_address;
               else checkOutput("addr_stable", avm_address, firstAddr);
               checkOutput("wb_active", 32'(wb_active), 32'(avm_write));
               if (avm_waitrequest) begin
                  checkOutput("rd_wait_stall", 32'(rd_waitrequest), 32'd1);
                  checkOutput("wb_wait_stall", 32'(wb_waitrequest), 32'd1);
               end else begin
                  checkOutput("scb_nonempty", 32'(scbQ.size() != 0), 32'd1);
                  if (scbQ.size() != 0) begin
                     e = scbQ.pop_front();
                     checkOutput("txn_kind", 32'(avm_write), 32'(e.isWrite));
                     checkOutput("txn_addr", avm_address, e.addr);
                     checkOutput("txn_be", 32'(avm_byteenable), 32'(e.be));
                     checkOutput("txn_cycles", 32'(strobeLen), 32'(e.cycles));
                     if (e.isWrite) begin
                        checkOutput("wr_data", avm_writedata, e.data);
                        checkOutput("wb_wait_done", 32'(wb_waitrequest), 32'd0);
                        checkOutput("rd_wait_idle", 32'(rd_waitrequest), 32'd1);
                     end else begin
                        checkOutput("rd_data", rd_readdata, e.data);
                        checkOutput("rd_wait_done", 32'(rd_waitrequest), 32'd0);
                        checkOutput("wb_wait_idle", 32'(wb_waitrequest), 32'd1);
                     end
                  end
                  doneCycles.push_back(cyc);
                  strobeLen = 0;
                  prevDone  = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      // Reset held two cycles with both requesters already asking.
      applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 0);
      applyStimulus(1'b1, 32'h0000_0200, 32'h1111_2222, 4'h3, 0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("rst_strobes", 32'({avm_read, avm_write, wb_active}), 32'd0);
         checkOutput("rst_waits", 32'({wb_waitrequest, rd_waitrequest}), 32'd3);
         checkOutput("rst_addr", avm_address, 32'd0);
         checkOutput("rst_rdata", rd_readdata, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("first_grant_read", 32'(avm_read), 32'd1);
      waitDrain("drain_reset");

      // Read with three wait states.
      waitStates = 3;
      applyStimulus(1'b0, 32'h1000_0040, 32'h0, 4'h0, 3);
      waitDrain("drain_read_wait");
      waitStates = 0;

      // Write-only drain: pulses every other cycle.
      doneCycles.delete();
      applyStimulus(1'b1, 32'h2000_0000, 32'hA000_0001, 4'hF, 0);
      applyStimulus(1'b1, 32'h2000_0004, 32'hA000_0002, 4'h1, 0);
      applyStimulus(1'b1, 32'h2000_0008, 32'hA000_0003, 4'hC, 0);
      waitDrain("drain_writes");
      checkOutput("write_count", 32'(doneCycles.size()), 32'd3);
      if (doneCycles.size() == 3) begin
         checkOutput("write_gap0", 32'(doneCycles[1] - doneCycles[0]), 32'd2);
         checkOutput("write_gap1", 32'(doneCycles[2] - doneCycles[1]), 32'd2);
      end
      checkOutput("wb_active_idle", 32'(wb_active), 32'd0);

      // Reads and writes both pending: expected grant order pushed in arbitration order.
`ifdef MIPS_ARB_STRICT_ORDER_EN
      applyStimulus(1'b1, 32'h4000_0000, 32'hB000_0000, 4'hF, 0);
      applyStimulus(1'b1, 32'h4000_0004, 32'hB000_0001, 4'hF, 0);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h5000_0000 + 32'(i * 4), 32'h0, 4'h0, 0);
`else
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h5000_0000 + 32'(i * 4), 32'h0, 4'h0, 0);
      applyStimulus(1'b1, 32'h4000_0000, 32'hB000_0000, 4'hF, 0);
      for (int i = 4; i < 8; i++) applyStimulus(1'b0, 32'h5000_0000 + 32'(i * 4), 32'h0, 4'h0, 0);
      applyStimulus(1'b1, 32'h4000_0004, 32'hB000_0001, 4'hF, 0);
`endif
      waitDrain("drain_starve");

      // Read request arriving during a stalled write.
      waitStates = 2;
      applyStimulus(1'b1, 32'h6000_0010, 32'hC0DE_0001, 4'h6, 2);
      @(negedge clk);
      checkOutput("mid_write_strobe", 32'(avm_write), 32'd1);
      applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'h0, 0);
      @(negedge clk);
      checkOutput("mid_addr_stall", avm_address, 32'h6000_0010);
      checkOutput("mid_no_read", 32'(avm_read), 32'd0);
      @(negedge clk);
      checkOutput("mid_addr_done", avm_address, 32'h6000_0010);
      @(posedge clk);
      #1 waitStates = 0;
      @(negedge clk);
      checkOutput("mid_turnaround", 32'(avm_read), 32'd0);
      @(negedge clk);
      checkOutput("mid_read_grant", 32'(avm_read), 32'd1);
      checkOutput("mid_read_addr", avm_address, 32'h3000_0000);
      waitDrain("drain_mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mips_cache_mem_arbiter.md
# mips_cache_mem_arbiter

Sole owner of the cache's Avalon memory master port. Arbitrates between the write buffer drain (writes) and cache read-miss fills (reads), and drives the write buffer's `active` gate. Reads have priority to cut miss latency; a bounded starvation counter keeps writes progressing. Sits between the cache controller/write buffer and the top-level Avalon bus.

## Interface
- `STARVE_LIMIT`, 4: consecutive reads granted while a write is pending before one write is forced; legal range 1–15.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `wb_write` in 1: write buffer has a write pending (its `write_writeenable`).
- `wb_addr` in 32: write address from the buffer.
- `wb_writedata` in 32: write data from the buffer.
- `wb_byteenable` in 4: write byte enables from the buffer.
- `wb_active` out 1: enables the write buffer drain.
- `wb_waitrequest` out 1: waitrequest returned to the write buffer.
- `rd_req` in 1: read-miss request; held high until accepted.
- `rd_addr` in 32: read address; sampled at grant.
- `rd_waitrequest` out 1: low for exactly the completing read cycle.
- `rd_readdata` out 32: read data; valid when `rd_waitrequest` is low.
- `avm_address` out 32: Avalon address.
- `avm_read` out 1: Avalon read strobe.
- `avm_write` out 1: Avalon write strobe.
- `avm_writedata` out 32: Avalon write data.
- `avm_byteenable` out 4: Avalon byte enables.
- `avm_waitrequest` in 1: Avalon waitrequest.
- `avm_readdata` in 32: Avalon read data; valid in the cycle `avm_waitrequest` is low.

## Operation
- States (`arb_state_t`): `ARB_IDLE`=0, `ARB_WRITE`=1, `ARB_READ`=2.
- `ARB_IDLE` → `ARB_READ`: `rd_req` is high and the write is not forced. Latch `rd_addr` into `addr_q`.
- `ARB_IDLE` → `ARB_WRITE`: `wb_write` is high and either `rd_req` is low or `streak == STARVE_LIMIT`.
- `ARB_IDLE`, nothing pending: remain in `ARB_IDLE`.
- `ARB_READ`:
  - Drive `avm_read=1`, `avm_address=addr_q`, `avm_byteenable=4'hF`.
  - When `avm_waitrequest=0`: drive `rd_waitrequest=0`, set `rd_readdata=avm_readdata`, go to `ARB_IDLE`.
- `ARB_WRITE`:
  - Drive `wb_active=1` and `avm_write=wb_write`.
  - Pass `wb_addr`, `wb_writedata` and `wb_byteenable` combinationally to the Avalon outputs.
  - `wb_waitrequest = avm_waitrequest`.
  - When `avm_waitrequest=0`, go to `ARB_IDLE`.
- Outside `ARB_WRITE`: `wb_active=0` and `wb_waitrequest=1`, so the write buffer never advances its pointer without a grant.
- `streak` counter:
  - Width is `$clog2(STARVE_LIMIT+1)`, saturating.
  - +1 when a read completes while `wb_write` is high.
  - Cleared when a write completes, or in any `ARB_IDLE` cycle with `wb_write` low.
- A transaction is never abandoned or altered mid-flight. `rd_addr` and `rd_req` changes during `ARB_READ` are ignored.
- `rd_req` arriving during `ARB_WRITE` waits until the write completes.
- Simultaneous `rd_req` and `wb_write` in `ARB_IDLE` are resolved by the streak rule above.
- Reset values:
  - State `ARB_IDLE`, `streak=0`, `addr_q=0`.
  - All outputs 0, except `wb_waitrequest=1` and `rd_waitrequest=1`.
- Reset mid-transaction drops the strobes the cycle after reset is sampled. No completion is owed to either requester; reset is system-wide.

## Timing
- Grant latency: request seen in `ARB_IDLE` at cycle N → strobe asserted at cycle N+1.
- Completion cycle is the cycle in which `avm_waitrequest=0`. The requester sees its waitrequest low in that same cycle (combinational pass-through).
- One mandatory `ARB_IDLE` turnaround cycle follows every transaction. Minimum throughput is one transaction per 2 cycles with zero-wait memory.
- `avm_read` and `avm_write` are never high together.

## Configuration
- `MIPS_ARB_STRICT_ORDER_EN` undefined: read-priority behaviour with the starvation counter, as above.
- `MIPS_ARB_STRICT_ORDER_EN` defined: strict ordering.
  - A read is granted only in an `ARB_IDLE` cycle with `wb_write` low, so the buffer fully drains before any read (no read-after-write hazard).
  - `streak` logic and `STARVE_LIMIT` have no effect and are compiled out.

## Structure
- Shared package `mips_cache_pkg` holds:
  - `arb_state_t`.
  - The `4'hF` full-word byteenable constant.
- One sub-module, `mips_cache_arb_streak_ctr`: the saturating counter plus its compare against `STARVE_LIMIT`. Omitted under `MIPS_ARB_STRICT_ORDER_EN`.
- Everything else lives in a single FSM module.

## Test plan
- **Reset:** hold `rst` 2 cycles with all requests high → all strobes 0, both waitrequests 1, `wb_active=0`; first grant occurs the cycle after `rst` falls.
- **Read with wait states:** `rd_req`, `rd_addr=32'h1000_0040`, `avm_waitrequest` high 3 cycles then low with `avm_readdata=32'hDEAD_BEEF` → `avm_read` high 4 cycles; `rd_waitrequest` low only in the 4th cycle with data `32'hDEAD_BEEF`.
- **Write-only drain:** `wb_write` high for 3 writes with zero-wait memory → 3 `avm_write` pulses 2 cycles apart, each with the matching address, data and byteenable; `wb_active` low in the idle cycles.
- **Starvation, `STARVE_LIMIT=4`:** `rd_req` and `wb_write` held high → grant order R,R,R,R,W,R,R,R,R,W.
- **Mid-flight read request:** `rd_req` asserted during a stalled write → `avm_address` stays the write address until completion; read grant one idle cycle later.
- **Strict mode (`MIPS_ARB_STRICT_ORDER_EN`):** 2 pending writes plus `rd_req` → both writes complete before `avm_read` asserts.
